// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Brief    : Instruction-fetch stage. Owns the fetch PC, issues one word
//            fetch at a time over req/ack, buffers returned words in a small
//            prefetch queue and hands them to decode with valid/ready.
//            Optional performance counters are enabled by IF_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0,
    parameter int               QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] ir,
    output logic [WIDTH-1:0] pc_out,
    output logic             ir_valid,
    input  logic             id_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc
`ifdef IF_PERF_EN
    ,
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_squashed
`endif
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    localparam logic [CNT_W-1:0] c_depth    = CNT_W'(QDEPTH);
    localparam logic [WIDTH-1:0] c_step     = WIDTH'(4);
    localparam logic [WIDTH-1:0] c_align_mk = ~WIDTH'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] w_fetch_pc_next;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] w_addr_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic             w_pop;
    logic             w_push;
    logic             w_discard;
    logic             w_space;
    logic             w_not_empty;

    logic [WIDTH-1:0] r_q_ir [QDEPTH];
    logic [WIDTH-1:0] r_q_pc [QDEPTH];

    // Handshake qualifiers; a redirect overrides both pop and push.
    always_comb begin
        w_not_empty  = (r_count != '0);
        w_pop        = w_not_empty && id_ready && !redirect;
        w_push       = (r_state == ST_WAIT) && imem_ack && !redirect;
        w_discard    = imem_ack && ((r_state == ST_DROP) ||
                                    ((r_state == ST_WAIT) && redirect));
        w_count_next = redirect ? '0
                                : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));
        w_space      = (w_count_next < c_depth);
    end

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_fetch_pc_next = r_fetch_pc;

        if (redirect) begin
            w_fetch_pc_next = redirect_pc & c_align_mk;
        end else if (w_push) begin
            w_fetch_pc_next = r_fetch_pc + c_step;
        end

        case (r_state)
            ST_IDLE: begin
                if (!redirect && w_space) begin
                    w_state_next = ST_WAIT;
                    w_addr_next  = r_fetch_pc;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    w_state_next = imem_ack ? ST_IDLE : ST_DROP;
                end else if (imem_ack) begin
                    // Back-to-back issue keeps one instruction per cycle.
                    if (w_space) begin
                        w_addr_next = r_fetch_pc + c_step;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_addr     <= w_addr_next;
            r_count    <= w_count_next;
            if (redirect) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Payload storage needs no reset: outputs are gated by the entry count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_ir[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr] <= r_addr;
        end
    end

    assign imem_req  = (r_state == ST_WAIT) || (r_state == ST_DROP);
    assign imem_addr = r_addr;
    assign ir_valid  = w_not_empty;
    assign ir        = w_not_empty ? r_q_ir[r_rd_ptr] : '0;
    assign pc_out    = w_not_empty ? r_q_pc[r_rd_ptr] : '0;

`ifdef IF_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_squashed;
    logic [31:0] w_squash_inc;

    always_comb begin
        w_squash_inc = (redirect ? 32'(r_count) : 32'd0) + 32'(w_discard);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched  <= '0;
            r_perf_squashed <= '0;
        end else begin
            r_perf_fetched  <= r_perf_fetched + 32'(w_pop);
            r_perf_squashed <= r_perf_squashed + w_squash_inc;
        end
    end

    assign perf_fetched  = r_perf_fetched;
    assign perf_squashed = r_perf_squashed;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Directed self-checking bench for if_fetch_queue (streaming,
//            back-pressure, memory latency, redirects, async reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] pc_out;
    logic        ir_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef IF_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_squashed;
`endif

    // Memory responder: automatic fixed latency, or ack driven by hand.
    logic        manual;
    logic        man_ack;
    int          mem_lat;
    int          lat_cnt;

    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_ack   = manual ? man_ack : (imem_req && (lat_cnt >= mem_lat));
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt <= 0;
        end else if (imem_req && !imem_ack) begin
            lat_cnt <= lat_cnt + 1;
        end else begin
            lat_cnt <= 0;
        end
    end

    if_fetch_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir          (ir),
        .pc_out      (pc_out),
        .ir_valid    (ir_valid),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef IF_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_squashed (perf_squashed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        manual      = 1'b0;
        man_ack     = 1'b0;
        mem_lat     = 0;
        id_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // 1: zero-wait memory, decode always ready
        do_reset();
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir",    ir, 32'h0);
        chk("rst_pc",    pc_out, 32'h0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("s1_addr", imem_addr, 32'(4 * (k - 1)));
            chk("s1_req",  {31'd0, imem_req}, 32'd1);
            if (k == 1) begin
                chk("s1_valid0", {31'd0, ir_valid}, 32'd0);
            end else begin
                chk("s1_valid", {31'd0, ir_valid}, 32'd1);
                chk("s1_pc",    pc_out, 32'(4 * (k - 2)));
                chk("s1_ir",    ir, mem_word(32'(4 * (k - 2))));
            end
        end

        // 2: back-pressure fills the two-entry queue, then fetch resumes
        id_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        chk("s2_req_off", {31'd0, imem_req}, 32'd0);
        chk("s2_pc0",     pc_out, 32'h0);
        tick();
        chk("s2_req_hold", {31'd0, imem_req}, 32'd0);
        chk("s2_pc0b",     pc_out, 32'h0);
        id_ready = 1'b1;
        tick();
        chk("s2_req_on", {31'd0, imem_req}, 32'd1);
        chk("s2_addr8",  imem_addr, 32'h8);
        chk("s2_pc4",    pc_out, 32'h4);
        tick();
        chk("s2_pc8",    pc_out, 32'h8);

        // 3: three cycles of memory latency
        mem_lat = 3;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("s3_addr0", imem_addr, 32'h0);
            chk("s3_req",   {31'd0, imem_req}, 32'd1);
            chk("s3_empty", {31'd0, ir_valid}, 32'd0);
        end
        tick();
        chk("s3_valid", {31'd0, ir_valid}, 32'd1);
        chk("s3_pc0",   pc_out, 32'h0);
        chk("s3_addr4", imem_addr, 32'h4);
        tick();
        chk("s3_gap", {31'd0, ir_valid}, 32'd0);
        tick();
        tick();
        tick();
        chk("s3_pc4", pc_out, 32'h4);

        // 4: redirect while the fetch of 8 is outstanding
        mem_lat  = 0;
        manual   = 1'b1;
        man_ack  = 1'b0;
        id_ready = 1'b0;
        do_reset();
        tick();
        man_ack = 1'b1;
        tick();
        tick();
        chk("s4_full_req", {31'd0, imem_req}, 32'd0);
        man_ack  = 1'b0;
        id_ready = 1'b1;
        tick();
        chk("s4_addr8", imem_addr, 32'h8);
        chk("s4_pc4",   pc_out, 32'h4);
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("s4_flush_v",  {31'd0, ir_valid}, 32'd0);
        chk("s4_flush_ir", ir, 32'h0);
        chk("s4_drop_req", {31'd0, imem_req}, 32'd1);
        chk("s4_drop_adr", imem_addr, 32'h8);
`ifdef IF_PERF_EN
        chk("s4_sq1", perf_squashed, 32'd1);
`endif
        tick();
        chk("s4_drop_hold", imem_addr, 32'h8);
        man_ack = 1'b1;
        tick();
        man_ack = 1'b0;
        chk("s4_idle_req", {31'd0, imem_req}, 32'd0);
        chk("s4_no_push",  {31'd0, ir_valid}, 32'd0);
`ifdef IF_PERF_EN
        chk("s4_sq2", perf_squashed, 32'd2);
`endif
        tick();
        chk("s4_new_req",  {31'd0, imem_req}, 32'd1);
        chk("s4_new_addr", imem_addr, 32'h100);
        man_ack = 1'b1;
        tick();
        chk("s4_new_pc", pc_out, 32'h100);
        chk("s4_new_ir", ir, mem_word(32'h100));
        chk("s4_next",   imem_addr, 32'h104);

        // 5: redirect coinciding with ack and pop
        id_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect = 1'b0;
        man_ack  = 1'b0;
        chk("s5_valid", {31'd0, ir_valid}, 32'd0);
        chk("s5_req",   {31'd0, imem_req}, 32'd0);
`ifdef IF_PERF_EN
        chk("s5_fetched", perf_fetched, 32'd1);
        chk("s5_sq",      perf_squashed, 32'd4);
`endif
        tick();
        chk("s5_req2",  {31'd0, imem_req}, 32'd1);
        chk("s5_addr2", imem_addr, 32'h200);

        // 6: asynchronous reset mid-fetch
        man_ack  = 1'b1;
        id_ready = 1'b0;
        tick();
        man_ack = 1'b0;
        chk("s6_pre_v",   {31'd0, ir_valid}, 32'd1);
        chk("s6_pre_req", {31'd0, imem_req}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s6_req",   {31'd0, imem_req}, 32'd0);
        chk("s6_valid", {31'd0, ir_valid}, 32'd0);
        chk("s6_ir",    ir, 32'h0);
        chk("s6_pc",    pc_out, 32'h0);
        chk("s6_addr",  imem_addr, 32'h0);
`ifdef IF_PERF_EN
        chk("s6_perf", perf_squashed, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        chk("s6_restart_req",  {31'd0, imem_req}, 32'd1);
        chk("s6_restart_addr", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
